// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (even parity, 11-bit frame).
package uart_tx_pkg;

  // Register word index (a[3:2]) for each byte offset.
  localparam logic [1:0] UART_DATA   = 2'd0;  // 0x0
  localparam logic [1:0] UART_STATUS = 2'd1;  // 0x4
  localparam logic [1:0] UART_DIV    = 2'd2;  // 0x8

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic [15:0] UART_DEFAULT_DIV = 16'd867;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Generic synchronous FIFO; extra pointer MSB distinguishes full from empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign dout    = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: bus-fed TX FIFO, programmable baud divisor.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  mask,
  input  logic [3:0]  a,
  input  logic [31:0] di,
  output logic [31:0] dout,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr, wr_data, wr_status, wr_div;
  logic          fifo_pop, full, empty;
  logic [7:0]    fifo_q;
  logic [CW-1:0] count;
  logic          overflow, busy;
  logic [15:0]   div, div_lat, timer;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          par;
  logic          tick;
  state_t        state, nxt;

  assign wr        = sel && we;
  assign wr_data   = wr && (a[3:2] == UART_DATA) && mask[0];
  assign wr_status = wr && (a[3:2] == UART_STATUS) && mask[0];
  assign wr_div    = wr && (a[3:2] == UART_DIV);
  assign tick      = (timer == 16'd0);

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .din   (di[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_q),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (wr_data && full)                overflow <= 1'b1;
      else if (wr_status && di[ST_OVF])   overflow <= 1'b0;
      if (wr_div && mask[0]) div[7:0]  <= di[7:0];
      if (wr_div && mask[1]) div[15:8] <= di[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (!empty) nxt = S_START;
      S_START:  if (tick) nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (tick && bit_idx == 3'd7) nxt = S_PARITY;
      S_PARITY: if (tick) nxt = S_STOP;
`else
      S_DATA:   if (tick && bit_idx == 3'd7) nxt = S_STOP;
`endif
      S_STOP:   if (tick) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Divisor is latched per frame so a mid-frame DIV write waits for the next one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      par     <= 1'b0;
      div_lat <= '0;
      timer   <= '0;
      bit_idx <= '0;
    end else if (state == S_IDLE) begin
      if (!empty) begin
        shreg   <= fifo_q;
        par     <= even_parity(fifo_q);
        div_lat <= div;
        timer   <= div;
        bit_idx <= '0;
      end
    end else if (tick) begin
      timer <= div_lat;
      if (state == S_DATA) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end else begin
      timer <= timer - 16'd1;
    end
  end

  always_comb begin
    fifo_pop = (state == S_IDLE) && !empty;
    busy     = (state != S_IDLE);
    case (state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd = par;
`endif
      default:  txd = 1'b1;
    endcase
  end

  logic [7:0] cnt8;
  assign cnt8 = 8'(count);

  always_comb begin
    dout = '0;
    if (sel) begin
      case (a[3:2])
        UART_STATUS: dout = {16'd0, cnt8, 4'd0, overflow, busy, empty, full};
        UART_DIV:    dout = {16'd0, div};
        default:     dout = '0;
      endcase
    end
  end

  logic unused;
  assign unused = ^{a[1:0], mask[3:2], di[31:16], di[7:4], di[2:0]};

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; expected txd comes from a frame model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0, we = 1'b0;
  logic [3:0]  mask = '0, a = '0;
  logic [31:0] di = '0;
  logic [31:0] dout;
  logic        txd;

  int errors = 0;
  int checks = 0;

  logic [7:0] fb [2];
  int         fd [2];
  int         nf;

  uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .mask  (mask),
    .a     (a),
    .di    (di),
    .dout  (dout),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] m);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; a = addr; di = data; mask = m;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; mask = '0;
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    sel = 1'b1; we = 1'b0; a = addr;
    #1 data = dout;
    sel = 1'b0;
  endtask

  function automatic logic bit_at(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Frames sent back to back, one idle-high cycle after each.
  function automatic logic exp_at(input int i);
    int r;
    int len;
    r = i;
    for (int f = 0; f < nf; f++) begin
      len = NB * (fd[f] + 1);
      if (r < len) return bit_at(fb[f], r / (fd[f] + 1));
      r -= len;
      if (r == 0) return 1'b1;
      r -= 1;
    end
    return 1'b1;
  endfunction

  logic [31:0] rv;
  int          zeros;
  int          total;

  initial begin
    // Reset and register defaults
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    rd(4'h4, rv); chk("reset_status", rv, 32'h2);
    rd(4'h8, rv); chk("reset_div", rv, 32'd867);
    rd(4'hC, rv); chk("reg_c_zero", rv, 32'd0);
    chk("sel0_do", dout, 32'd0);

    // DIV=3, single 0x55 frame
    wr(4'h8, 32'd3, 4'b0011);
    rd(4'h8, rv); chk("div3_read", rv, 32'd3);
    wr(4'h0, 32'h55, 4'b0001);
    @(negedge clk);
    fb[0] = 8'h55; fd[0] = 3; nf = 1;
    for (int i = 0; i <= NB * 4; i++) begin
      chk($sformatf("f55_txd[%0d]", i), {31'd0, txd}, {31'd0, exp_at(i)});
      if (i == NB * 4 - 1) begin rd(4'h4, rv); chk("f55_busy_last", {31'd0, rv[2]}, 32'd1); end
      if (i == NB * 4)     begin rd(4'h4, rv); chk("f55_idle_status", rv, 32'h2); end
      @(negedge clk);
    end

    // DIV=0, two bytes on consecutive cycles
    wr(4'h8, 32'd0, 4'b0011);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; a = 4'h0; mask = 4'b0001; di = 32'hA5;
    @(negedge clk);
    di = 32'h3C;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; mask = '0;
    fb[0] = 8'hA5; fd[0] = 0; fb[1] = 8'h3C; fd[1] = 0; nf = 2;
    for (int i = 0; i <= 2 * NB + 1; i++) begin
      chk($sformatf("b2b_txd[%0d]", i), {31'd0, txd}, {31'd0, exp_at(i)});
      if (i == 0) begin rd(4'h4, rv); chk("b2b_count1", rv, 32'h104); end
      @(negedge clk);
    end

    // FIFO overflow: 10 pushes in 10 cycles, DIV=100
    wr(4'h8, 32'd100, 4'b0011);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sel = 1'b1; we = 1'b1; a = 4'h0; mask = 4'b0001; di = 32'(k + 1);
    end
    @(negedge clk);
    sel = 1'b0; we = 1'b0; mask = '0;
    rd(4'h4, rv); chk("ovf_status", rv, 32'h80D);
    chk("ovf_txd_start", {31'd0, txd}, 32'd0);
    wr(4'h4, 32'h8, 4'b0001);
    rd(4'h4, rv); chk("ovf_cleared", rv, 32'h805);

    // Reset mid-DATA with 3 queued
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    rd(4'h4, rv); chk("rst1_status", rv, 32'h2);
    wr(4'h8, 32'd3, 4'b0011);
    wr(4'h0, 32'hFF, 4'b0001);
    wr(4'h0, 32'h11, 4'b0001);
    wr(4'h0, 32'h22, 4'b0001);
    wr(4'h0, 32'h33, 4'b0001);
    rd(4'h4, rv); chk("mid_count3", rv, 32'h304);
    repeat (4) @(negedge clk);
    chk("mid_data_txd", {31'd0, txd}, 32'd1);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    chk("rst2_txd", {31'd0, txd}, 32'd1);
    rd(4'h4, rv); chk("rst2_status", rv, 32'h2);
    rd(4'h8, rv); chk("rst2_div", rv, 32'd867);
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    chk("rst2_no_frames", 32'(zeros), 32'd0);

    // DIV write mid-frame applies to the next frame only
    wr(4'h8, 32'd3, 4'b0011);
    wr(4'h0, 32'h0F, 4'b0001);
    @(negedge clk);
    fb[0] = 8'h0F; fd[0] = 3; fb[1] = 8'hF0; fd[1] = 7; nf = 2;
    total = NB * 4 + 1 + NB * 8;
    for (int i = 0; i <= total; i++) begin
      chk($sformatf("divchg_txd[%0d]", i), {31'd0, txd}, {31'd0, exp_at(i)});
      if (i == 2) begin sel = 1'b1; we = 1'b1; a = 4'h8; mask = 4'b0011; di = 32'd7; end
      if (i == 3) begin a = 4'h0; mask = 4'b0001; di = 32'hF0; end
      if (i == 4) begin sel = 1'b0; we = 1'b0; mask = '0; end
      @(negedge clk);
    end
    rd(4'h4, rv); chk("divchg_idle", rv, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
